// File: rtl/stochastic_search_controller.sv
// Stages host clauses onto a local-search engine, then iterates its best-gain moves until no gain or max reached.
// Every output is registered (one cycle after the deciding edge); host loads are refused (out_load_ready=0) outside IDLE.
module stochastic_search_controller #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
    parameter int LOAD_HOLD_CYCLES                            = 2,
    localparam int NI = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int NB = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int NC = 1 << MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int XW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int CI = (NI + 1) * MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int CB = 2 * NB,
    localparam int AI = NI * MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE,
    localparam int G  = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1
) (
    input  logic          in_clk,
    input  logic          in_reset,
    input  logic          in_load_valid,
    output logic          out_load_ready,
    input  logic [XW-1:0] in_load_clause_index,
    input  logic [CI-1:0] in_load_coefficients_integer,
    input  logic [CB-1:0] in_load_coefficients_boolean,
    input  logic          in_clear,
    input  logic          in_start,
    input  logic [AI-1:0] in_init_integer,
    input  logic [NB-1:0] in_init_boolean,
    input  logic [7:0]    in_max_iterations,
    output logic [7:0]    out_current_state,
    output logic [XW-1:0] out_clause_index,
    output logic [CI-1:0] out_clause_coefficients_integer,
    output logic [CB-1:0] out_clause_coefficients_boolean,
    output logic [NC-1:0] out_existing_clauses,
    output logic [AI-1:0] out_integer_current_assigmnets,
    output logic [NB-1:0] out_boolean_current_assigmnets,
    input  logic          in_search_ready,
    input  logic [G-1:0]  in_bestgain,
    input  logic [AI-1:0] in_best_assignment_integer,
    input  logic [NB-1:0] in_best_assignment_boolean,
    output logic          out_busy,
    output logic          out_done,
    output logic          out_error,
    output logic [AI-1:0] out_result_integer,
    output logic [NB-1:0] out_result_boolean,
    output logic [7:0]    out_iterations
);

    localparam int HW = (LOAD_HOLD_CYCLES > 1) ? $clog2(LOAD_HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_UPDATE, ST_FINISH} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            run_first_q, run_first_d;
    logic [7:0]      max_q, max_d;
    logic [G-1:0]    gain_q, gain_d;
    logic [AI-1:0]   best_int_q, best_int_d;
    logic [NB-1:0]   best_bool_q, best_bool_d;
    logic            load_ready_q, load_ready_d;
    logic [7:0]      cur_state_q, cur_state_d;
    logic [XW-1:0]   clause_idx_q, clause_idx_d;
    logic [CI-1:0]   clause_ci_q, clause_ci_d;
    logic [CB-1:0]   clause_cb_q, clause_cb_d;
    logic [NC-1:0]   mask_q, mask_d;
    logic [AI-1:0]   cur_int_q, cur_int_d;
    logic [NB-1:0]   cur_bool_q, cur_bool_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [AI-1:0]   res_int_q, res_int_d;
    logic [NB-1:0]   res_bool_q, res_bool_d;
    logic [7:0]      iter_q, iter_d;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        run_first_d  = run_first_q;
        max_d        = max_q;
        gain_d       = gain_q;
        best_int_d   = best_int_q;
        best_bool_d  = best_bool_q;
        clause_idx_d = clause_idx_q;
        clause_ci_d  = clause_ci_q;
        clause_cb_d  = clause_cb_q;
        mask_d       = mask_q;
        cur_int_d    = cur_int_q;
        cur_bool_d   = cur_bool_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        res_int_d    = res_int_q;
        res_bool_d   = res_bool_q;
        iter_d       = iter_q;

        case (state_q)
            ST_IDLE: begin
                // Clear outranks load, which outranks start.
                if (in_clear) begin
                    mask_d = '0;
                end else if (in_load_valid && load_ready_q) begin
                    clause_idx_d                 = in_load_clause_index;
                    clause_ci_d                  = in_load_coefficients_integer;
                    clause_cb_d                  = in_load_coefficients_boolean;
                    mask_d[in_load_clause_index] = 1'b1;
                    hold_cnt_d                   = '0;
                    state_d                      = ST_LOAD;
                end else if (in_start && !in_load_valid) begin
                    if (mask_q == '0) begin
                        error_d = 1'b1;
                    end else if (in_max_iterations == 8'd0) begin
                        res_int_d  = in_init_integer;
                        res_bool_d = in_init_boolean;
                        iter_d     = 8'd0;
                        done_d     = 1'b1;
                    end else begin
                        cur_int_d   = in_init_integer;
                        cur_bool_d  = in_init_boolean;
                        max_d       = in_max_iterations;
                        iter_d      = 8'd0;
                        run_first_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_LOAD: begin
                if (hold_cnt_q == HW'(LOAD_HOLD_CYCLES - 1)) state_d = ST_IDLE;
                else hold_cnt_d = hold_cnt_q + 1'b1;
            end
            ST_RUN: begin
                // The engine needs one cycle to see the new assignment before its answer is trusted.
                if (run_first_q) begin
                    run_first_d = 1'b0;
                end else if (in_search_ready) begin
                    gain_d      = in_bestgain;
                    best_int_d  = in_best_assignment_integer;
                    best_bool_d = in_best_assignment_boolean;
                    state_d     = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (gain_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    cur_int_d   = best_int_q;
                    cur_bool_d  = best_bool_q;
                    iter_d      = iter_q + 8'd1;
                    run_first_d = 1'b1;
                    state_d     = (iter_d == max_q) ? ST_FINISH : ST_RUN;
                end
            end
            ST_FINISH: begin
                res_int_d  = cur_int_q;
                res_bool_d = cur_bool_q;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        load_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        cur_state_d  = (state_d == ST_LOAD) ? 8'd1 : (state_d == ST_RUN) ? 8'd3 : 8'd0;
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            run_first_q  <= 1'b0;
            max_q        <= '0;
            gain_q       <= '0;
            best_int_q   <= '0;
            best_bool_q  <= '0;
            load_ready_q <= 1'b0;
            cur_state_q  <= '0;
            clause_idx_q <= '0;
            clause_ci_q  <= '0;
            clause_cb_q  <= '0;
            mask_q       <= '0;
            cur_int_q    <= '0;
            cur_bool_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            res_int_q    <= '0;
            res_bool_q   <= '0;
            iter_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            run_first_q  <= run_first_d;
            max_q        <= max_d;
            gain_q       <= gain_d;
            best_int_q   <= best_int_d;
            best_bool_q  <= best_bool_d;
            load_ready_q <= load_ready_d;
            cur_state_q  <= cur_state_d;
            clause_idx_q <= clause_idx_d;
            clause_ci_q  <= clause_ci_d;
            clause_cb_q  <= clause_cb_d;
            mask_q       <= mask_d;
            cur_int_q    <= cur_int_d;
            cur_bool_q   <= cur_bool_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            res_int_q    <= res_int_d;
            res_bool_q   <= res_bool_d;
            iter_q       <= iter_d;
        end
    end

    assign out_load_ready                  = load_ready_q;
    assign out_current_state               = cur_state_q;
    assign out_clause_index                = clause_idx_q;
    assign out_clause_coefficients_integer = clause_ci_q;
    assign out_clause_coefficients_boolean = clause_cb_q;
    assign out_existing_clauses            = mask_q;
    assign out_integer_current_assigmnets  = cur_int_q;
    assign out_boolean_current_assigmnets  = cur_bool_q;
    assign out_busy                        = busy_q;
    assign out_done                        = done_q;
    assign out_error                       = error_q;
    assign out_result_integer              = res_int_q;
    assign out_result_boolean              = res_bool_q;
    assign out_iterations                  = iter_q;

endmodule

// File: tb/tb_stochastic_search_controller.sv
// Randomized bench for stochastic_search_controller against a round-by-round search model.
module tb_stochastic_search_controller;

    logic        clk = 1'b0;
    logic        in_reset;
    logic        in_load_valid, out_load_ready;
    logic [1:0]  in_load_clause_index;
    logic [11:0] in_load_coefficients_integer;
    logic [3:0]  in_load_coefficients_boolean;
    logic        in_clear, in_start;
    logic [7:0]  in_init_integer;
    logic [1:0]  in_init_boolean;
    logic [7:0]  in_max_iterations;
    logic [7:0]  out_current_state;
    logic [1:0]  out_clause_index;
    logic [11:0] out_clause_coefficients_integer;
    logic [3:0]  out_clause_coefficients_boolean;
    logic [3:0]  out_existing_clauses;
    logic [7:0]  out_integer_current_assigmnets;
    logic [1:0]  out_boolean_current_assigmnets;
    logic        in_search_ready;
    logic [2:0]  in_bestgain;
    logic [7:0]  in_best_assignment_integer;
    logic [1:0]  in_best_assignment_boolean;
    logic        out_busy, out_done, out_error;
    logic [7:0]  out_result_integer;
    logic [1:0]  out_result_boolean;
    logic [7:0]  out_iterations;

    stochastic_search_controller dut (
        .in_clk(clk), .in_reset(in_reset),
        .in_load_valid(in_load_valid), .out_load_ready(out_load_ready),
        .in_load_clause_index(in_load_clause_index),
        .in_load_coefficients_integer(in_load_coefficients_integer),
        .in_load_coefficients_boolean(in_load_coefficients_boolean),
        .in_clear(in_clear), .in_start(in_start),
        .in_init_integer(in_init_integer), .in_init_boolean(in_init_boolean),
        .in_max_iterations(in_max_iterations),
        .out_current_state(out_current_state), .out_clause_index(out_clause_index),
        .out_clause_coefficients_integer(out_clause_coefficients_integer),
        .out_clause_coefficients_boolean(out_clause_coefficients_boolean),
        .out_existing_clauses(out_existing_clauses),
        .out_integer_current_assigmnets(out_integer_current_assigmnets),
        .out_boolean_current_assigmnets(out_boolean_current_assigmnets),
        .in_search_ready(in_search_ready), .in_bestgain(in_bestgain),
        .in_best_assignment_integer(in_best_assignment_integer),
        .in_best_assignment_boolean(in_best_assignment_boolean),
        .out_busy(out_busy), .out_done(out_done), .out_error(out_error),
        .out_result_integer(out_result_integer), .out_result_boolean(out_result_boolean),
        .out_iterations(out_iterations)
    );

    always #5 clk = ~clk;

    wire [61:0] all_out = {out_load_ready, out_current_state, out_clause_index,
                           out_clause_coefficients_integer, out_clause_coefficients_boolean,
                           out_existing_clauses, out_integer_current_assigmnets,
                           out_boolean_current_assigmnets, out_busy, out_done, out_error,
                           out_result_integer, out_result_boolean, out_iterations};

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [3:0] exp_mask;

    // Engine script: response k is what the engine offers during the k-th RUN round.
    logic [2:0] resp_gain [16];
    logic [7:0] resp_int  [16];
    logic [1:0] resp_bool [16];

    logic [7:0] ob_it, ob_ri;
    logic [1:0] ob_rb;
    logic [9:0] ob_first_cur;
    int ob_rounds, ob_done, ob_min_run, ob_max_run, ob_busy_bad;
    bit ob_timeout;

    task automatic model_search(input logic [7:0] ii, input logic [1:0] ib, input logic [7:0] mx,
                                output logic [7:0] e_it, output logic [7:0] e_ri,
                                output logic [1:0] e_rb, output int e_rounds);
        e_ri = ii; e_rb = ib; e_it = 8'd0; e_rounds = 0;
        while (e_rounds < 16) begin
            e_rounds++;
            if (resp_gain[e_rounds-1] == 3'd0) break;
            e_ri = resp_int[e_rounds-1];
            e_rb = resp_bool[e_rounds-1];
            e_it++;
            if (e_it == mx) break;
        end
    endtask

    task automatic drive_resp(input int k);
        int j;
        j = (k > 15) ? 15 : k;
        in_bestgain                = resp_gain[j];
        in_best_assignment_integer = resp_int[j];
        in_best_assignment_boolean = resp_bool[j];
    endtask

    task automatic do_search(input logic [7:0] ii, input logic [1:0] ib, input logic [7:0] mx,
                             input bit rand_ready);
        int prev_state, runlen, after;
        ob_rounds = 0; ob_done = 0; ob_min_run = 1000; ob_max_run = 0; ob_busy_bad = 0;
        ob_timeout = 1'b1;
        @(negedge clk);
        in_init_integer = ii; in_init_boolean = ib; in_max_iterations = mx; in_start = 1'b1;
        drive_resp(0);
        in_search_ready = rand_ready ? 1'($urandom) : 1'b1;
        prev_state = 0; runlen = 0; after = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            in_start = 1'b0;
            if (cyc == 0) ob_first_cur = {out_integer_current_assigmnets, out_boolean_current_assigmnets};
            if (out_current_state == 8'd3) begin
                runlen++;
                if (out_busy !== 1'b1) ob_busy_bad++;
            end else if (prev_state == 3) begin
                if (runlen < ob_min_run) ob_min_run = runlen;
                if (runlen > ob_max_run) ob_max_run = runlen;
                ob_rounds++;
                drive_resp(ob_rounds);
                runlen = 0;
            end
            if (out_done === 1'b1) begin
                ob_done++;
                ob_ri = out_result_integer; ob_rb = out_result_boolean; ob_it = out_iterations;
                if (after < 0) after = 4;
            end
            prev_state = int'(out_current_state);
            in_search_ready = rand_ready ? 1'($urandom) : 1'b1;
            if (after > 0) begin
                after--;
                if (after == 0) begin ob_timeout = 1'b0; break; end
            end
        end
        in_search_ready = 1'b0;
    endtask

    task automatic load_clause(input logic [1:0] idx, input logic [11:0] ci, input logic [3:0] cb);
        int n;
        n = 0;
        @(negedge clk);
        while (out_load_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            err_cnt++;
            $display("FAIL load_wait: out_load_ready=%b required 1 within 20 cycles", out_load_ready);
        end
        in_load_valid = 1'b1; in_load_clause_index = idx;
        in_load_coefficients_integer = ci; in_load_coefficients_boolean = cb;
        @(negedge clk);
        in_load_valid = 1'b0;
        exp_mask[idx] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        in_reset = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (all_out !== 62'd0) begin
            err_cnt++; $display("FAIL reset_zero: outputs=%h required 0", all_out);
        end
        in_reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({out_load_ready, out_busy, out_current_state} !== {1'b1, 1'b0, 8'd0}) begin
            err_cnt++;
            $display("FAIL reset_release: ready/busy/state=%b/%b/%0d required 1/0/0",
                     out_load_ready, out_busy, out_current_state);
        end
        exp_mask = 4'd0;
    endtask

    task automatic test_load;
        logic [11:0] tbl_ci [4];
        logic [3:0]  tbl_cb [4];
        logic [1:0]  idx;
        logic [11:0] ci;
        logic [3:0]  cb;
        int hold, n;
        tbl_ci[0] = 12'h411; tbl_ci[1] = 12'h511; tbl_ci[2] = 12'h611; tbl_ci[3] = 12'h311;
        tbl_cb[0] = 4'hF;    tbl_cb[1] = 4'hB;    tbl_cb[2] = 4'hB;    tbl_cb[3] = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin idx = 2'(k); ci = tbl_ci[k]; cb = tbl_cb[k]; end
            else begin idx = 2'($urandom); ci = 12'($urandom); cb = 4'($urandom); end
            n = 0;
            while (out_load_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            in_load_valid = 1'b1; in_load_clause_index = idx;
            in_load_coefficients_integer = ci; in_load_coefficients_boolean = cb;
            @(negedge clk);
            in_load_valid = 1'b0;
            exp_mask[idx] = 1'b1;
            hold = 0;
            for (int c = 0; c < 6; c++) begin
                if (out_current_state != 8'd1) break;
                hold++;
                vec_cnt++;
                if ({out_clause_index, out_clause_coefficients_integer, out_clause_coefficients_boolean,
                     out_busy} !== {idx, ci, cb, 1'b1}) begin
                    err_cnt++;
                    $display("FAIL load_bus k=%0d: idx/ci/cb/busy=%0d/%h/%h/%b required %0d/%h/%h/1",
                             k, out_clause_index, out_clause_coefficients_integer,
                             out_clause_coefficients_boolean, out_busy, idx, ci, cb);
                end
                // Load and start offered while loading must be ignored.
                if (c == 0) begin
                    in_load_valid = 1'b1; in_start = 1'b1; in_max_iterations = 8'd4;
                    in_load_clause_index = ~idx; in_load_coefficients_integer = ~ci;
                end
                @(negedge clk);
                in_load_valid = 1'b0; in_start = 1'b0;
            end
            vec_cnt++;
            if (hold !== 2 || out_existing_clauses !== exp_mask || out_load_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL load_hold k=%0d: cycles/mask/ready=%0d/%b/%b required 2/%b/1",
                         k, hold, out_existing_clauses, out_load_ready, exp_mask);
            end
            if (k == 3) begin
                vec_cnt++;
                if (out_existing_clauses !== 4'b1111) begin
                    err_cnt++; $display("FAIL load_mask_full: mask=%b required 1111", out_existing_clauses);
                end
            end
        end
    endtask

    task automatic check_search(input string name, input logic [7:0] ii, input logic [1:0] ib,
                                input logic [7:0] mx, input bit rand_ready);
        logic [7:0] e_it, e_ri;
        logic [1:0] e_rb;
        int e_rounds;
        model_search(ii, ib, mx, e_it, e_ri, e_rb, e_rounds);
        do_search(ii, ib, mx, rand_ready);
        vec_cnt++;
        if (ob_timeout || ob_done !== 1 || ob_it !== e_it || {ob_ri, ob_rb} !== {e_ri, e_rb}
            || ob_rounds !== e_rounds || ob_busy_bad !== 0) begin
            err_cnt++;
            $display("FAIL %s: timeout=%b done=%0d iter=%0d res=%h/%b rounds=%0d busybad=%0d required done=1 iter=%0d res=%h/%b rounds=%0d",
                     name, ob_timeout, ob_done, ob_it, ob_ri, ob_rb, ob_rounds, ob_busy_bad,
                     e_it, e_ri, e_rb, e_rounds);
        end
        vec_cnt++;
        if (ob_first_cur !== {ii, ib} || ob_min_run < 2 || (!rand_ready && ob_max_run !== 2)) begin
            err_cnt++;
            $display("FAIL %s_run: first_cur=%h run_len min/max=%0d/%0d required cur=%h min>=2",
                     name, ob_first_cur, ob_min_run, ob_max_run, {ii, ib});
        end
    endtask

    task automatic test_search_directed;
        for (int i = 0; i < 16; i++) begin
            resp_gain[i] = 3'd0; resp_int[i] = 8'($urandom); resp_bool[i] = 2'($urandom);
        end
        resp_gain[0] = 3'd2;
        check_search("gain2_then_0", 8'h11, 2'b10, 8'd5, 1'b0);
    endtask

    task automatic test_search_gain1;
        for (int i = 0; i < 16; i++) begin
            resp_gain[i] = 3'd1; resp_int[i] = 8'($urandom); resp_bool[i] = 2'($urandom);
        end
        check_search("gain1_max3", 8'h11, 2'b10, 8'd3, 1'b0);
    endtask

    task automatic test_search_random;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                resp_gain[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                resp_int[i]  = 8'($urandom); resp_bool[i] = 2'($urandom);
            end
            resp_gain[15] = 3'd0;
            check_search("random_search", 8'($urandom), 2'($urandom), 8'($urandom_range(1, 12)),
                         r[0]);
        end
    endtask

    task automatic test_clear_error;
        @(negedge clk);
        in_clear = 1'b1; in_load_valid = 1'b1; in_start = 1'b1; in_max_iterations = 8'd5;
        in_load_clause_index = 2'd1;
        @(negedge clk);
        in_clear = 1'b0; in_load_valid = 1'b0; in_start = 1'b0;
        exp_mask = 4'd0;
        vec_cnt++;
        if ({out_existing_clauses, out_current_state, out_error} !== {4'd0, 8'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL clear_priority: mask/state/error=%b/%0d/%b required 0000/0/0",
                     out_existing_clauses, out_current_state, out_error);
        end
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        vec_cnt++;
        if ({out_error, out_current_state, out_done} !== {1'b1, 8'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL start_empty_error: error/state/done=%b/%0d/%b required 1/0/0",
                     out_error, out_current_state, out_done);
        end
        @(negedge clk);
        vec_cnt++;
        if ({out_error, out_busy, out_current_state} !== {1'b0, 1'b0, 8'd0}) begin
            err_cnt++;
            $display("FAIL error_pulse: error/busy/state=%b/%b/%0d required 0/0/0",
                     out_error, out_busy, out_current_state);
        end
    endtask

    task automatic test_max_zero;
        load_clause(2'd1, 12'h511, 4'hB);
        in_init_integer = 8'h11; in_init_boolean = 2'b10; in_max_iterations = 8'd0; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        vec_cnt++;
        if ({out_done, out_error, out_result_integer, out_result_boolean, out_iterations, out_current_state}
            !== {1'b1, 1'b0, 8'h11, 2'b10, 8'd0, 8'd0}) begin
            err_cnt++;
            $display("FAIL max_zero: done/err/res/iter/state=%b/%b/%h/%b/%0d/%0d required 1/0/11/10/0/0",
                     out_done, out_error, out_result_integer, out_result_boolean, out_iterations,
                     out_current_state);
        end
        @(negedge clk);
        vec_cnt++;
        if (out_done !== 1'b0) begin
            err_cnt++; $display("FAIL max_zero_pulse: done=%b required 0", out_done);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        in_load_valid = 1'b1; in_start = 1'b1; in_max_iterations = 8'd3;
        in_load_clause_index = 2'd2; in_load_coefficients_integer = 12'h6A5;
        in_load_coefficients_boolean = 4'h9;
        @(negedge clk);
        in_load_valid = 1'b0; in_start = 1'b0; exp_mask[2] = 1'b1;
        vec_cnt++;
        if ({out_current_state, out_clause_index, out_clause_coefficients_integer} !== {8'd1, 2'd2, 12'h6A5}) begin
            err_cnt++;
            $display("FAIL load_beats_start: state/idx/ci=%0d/%0d/%h required 1/2/6a5",
                     out_current_state, out_clause_index, out_clause_coefficients_integer);
        end
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({out_current_state, out_busy, out_existing_clauses} !== {8'd0, 1'b0, exp_mask}) begin
            err_cnt++;
            $display("FAIL start_dropped: state/busy/mask=%0d/%b/%b required 0/0/%b",
                     out_current_state, out_busy, out_existing_clauses, exp_mask);
        end
    endtask

    task automatic test_reset_mid_run;
        for (int i = 0; i < 16; i++) resp_gain[i] = 3'd1;
        drive_resp(0);
        in_search_ready = 1'b0;
        @(negedge clk);
        in_init_integer = 8'h5C; in_init_boolean = 2'b01; in_max_iterations = 8'd5; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        vec_cnt++;
        if ({out_current_state, out_busy, out_integer_current_assigmnets} !== {8'd3, 1'b1, 8'h5C}) begin
            err_cnt++;
            $display("FAIL run_entry: state/busy/cur=%0d/%b/%h required 3/1/5c",
                     out_current_state, out_busy, out_integer_current_assigmnets);
        end
        repeat (3) @(negedge clk);
        in_reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (all_out !== 62'd0) begin
            err_cnt++; $display("FAIL reset_mid_run: outputs=%h required 0", all_out);
        end
        in_reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (all_out !== {1'b1, 61'd0}) begin
            err_cnt++; $display("FAIL reset_mid_run_release: outputs=%h required ready only", all_out);
        end
        exp_mask = 4'd0;
    endtask

    task automatic test_reset_mid_load;
        @(negedge clk);
        in_load_valid = 1'b1; in_load_clause_index = 2'd3;
        in_load_coefficients_integer = 12'h311; in_load_coefficients_boolean = 4'hF;
        @(negedge clk);
        in_load_valid = 1'b0;
        vec_cnt++;
        if ({out_current_state, out_existing_clauses} !== {8'd1, 4'b1000}) begin
            err_cnt++;
            $display("FAIL load_after_reset: state/mask=%0d/%b required 1/1000",
                     out_current_state, out_existing_clauses);
        end
        in_reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (all_out !== 62'd0) begin
            err_cnt++; $display("FAIL reset_mid_load: outputs=%h required 0", all_out);
        end
        in_reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        in_reset = 1'b0; in_load_valid = 1'b0; in_load_clause_index = '0;
        in_load_coefficients_integer = '0; in_load_coefficients_boolean = '0;
        in_clear = 1'b0; in_start = 1'b0; in_init_integer = '0; in_init_boolean = '0;
        in_max_iterations = '0; in_search_ready = 1'b0; in_bestgain = '0;
        in_best_assignment_integer = '0; in_best_assignment_boolean = '0;
        exp_mask = 4'd0;
        test_reset;
        test_load;
        test_search_directed;
        test_search_gain1;
        test_search_random;
        test_clear_error;
        test_max_zero;
        test_collision;
        test_reset_mid_run;
        test_reset_mid_load;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
